// File: rtl/particle_flight.sv
// particle_flight: ballistic projectile for a two-player throwing game.
// A rising edge on throw_flag in IDLE launches a particle from the current
// player's launch point. Its position is stepped once every TICK_DIV clocks
// under constant gravity until it strikes the opponent's box, reaches the
// ground line or leaves the visible columns.
// Optional build macro: PARTICLE_WIND_EN. When it is defined, the latched
// wind code nudges x by (wind - 4) on every 4th tick. When it is undefined,
// the wind input is ignored.
module particle_flight #(
   parameter int TICK_DIV = 1_000_000,
   parameter int CAT_X    = 100,
   parameter int CAT_Y    = 500,
   parameter int DOG_X    = 660,
   parameter int DOG_Y    = 500,
   parameter int GROUND_Y = 560,
   parameter int X_MAX    = 799,
   parameter int TGT_W    = 64
) (
   input  logic        clk60MHz,
   input  logic        rst,
   input  logic        throw_flag,
   input  logic        turn,
   input  logic [4:0]  power,
   input  logic [2:0]  wind,
   output logic [11:0] xpos_particle,
   output logic [11:0] ypos_particle,
   output logic        busy,
   output logic        end_throw,
   output logic        hit
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   localparam logic signed [12:0] CAT_X_S     = 13'(CAT_X);
   localparam logic signed [12:0] CAT_Y_S     = 13'(CAT_Y);
   localparam logic signed [12:0] DOG_X_S     = 13'(DOG_X);
   localparam logic signed [12:0] DOG_Y_S     = 13'(DOG_Y);
   localparam logic signed [12:0] CAT_X_END   = 13'(CAT_X + TGT_W);
   localparam logic signed [12:0] CAT_Y_END   = 13'(CAT_Y + TGT_W);
   localparam logic signed [12:0] DOG_X_END   = 13'(DOG_X + TGT_W);
   localparam logic signed [12:0] DOG_Y_END   = 13'(DOG_Y + TGT_W);
   localparam logic signed [12:0] GROUND_Y_S  = 13'(GROUND_Y);
   localparam logic signed [12:0] X_MAX_S     = 13'(X_MAX);

   typedef enum logic [1:0] {
      IDLE,
      FLIGHT,
      DONE
   } state_t;

   state_t                  state_q;
   logic                    throw_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    dir_q;      // 0: moving right (cat), 1: moving left (dog)
   logic signed [12:0]      vx_q;
   logic signed [12:0]      vy_q;
   logic signed [12:0]      x_q;
   logic signed [12:0]      y_q;
   logic                    busy_q;
   logic                    end_q;
   logic                    hit_q;
`ifdef PARTICLE_WIND_EN
   logic [2:0]              wind_q;
   logic [1:0]              phase_q;    // tick index modulo 4 since launch
`endif

   logic                    rise;
   logic                    tick;
   logic signed [12:0]      launch_x;
   logic signed [12:0]      launch_y;
   logic signed [12:0]      box_x_lo;
   logic signed [12:0]      box_x_hi;
   logic signed [12:0]      box_y_lo;
   logic signed [12:0]      box_y_hi;
   logic signed [12:0]      step_x;
   logic signed [12:0]      x_d;
   logic signed [12:0]      y_d;
   logic signed [12:0]      vy_d;
   logic signed [12:0]      x_clamped;
   logic signed [12:0]      y_clamped;
   logic                    in_box;
   logic                    at_ground;
   logic                    off_left;
   logic                    off_right;
   logic                    term;
   logic                    unused_bits;

   // Launch edge detect, tick strobe and launch point of the current turn.
   always_comb begin
      rise     = throw_flag & ~throw_q;
      tick     = (cnt_q == CNT_LAST);
      launch_x = turn ? DOG_X_S : CAT_X_S;
      launch_y = turn ? DOG_Y_S : CAT_Y_S;
   end

   // Opponent box of the player whose throw is in flight.
   always_comb begin
      box_x_lo = dir_q ? CAT_X_S   : DOG_X_S;
      box_x_hi = dir_q ? CAT_X_END : DOG_X_END;
      box_y_lo = dir_q ? CAT_Y_S   : DOG_Y_S;
      box_y_hi = dir_q ? CAT_Y_END : DOG_Y_END;
   end

   // Next position and velocity for one physics tick.
   always_comb begin
      step_x = dir_q ? -vx_q : vx_q;
      x_d    = x_q + step_x;
`ifdef PARTICLE_WIND_EN
      if (phase_q == 2'd3) begin
         x_d = x_d + $signed({10'd0, wind_q}) - 13'sd4;
      end
`endif
      y_d  = y_q + vy_q;
      vy_d = vy_q + 13'sd1;
   end

   // Termination tests on the new position and the clamped landing point.
   always_comb begin
      in_box    = (x_d >= box_x_lo) && (x_d < box_x_hi) &&
                  (y_d >= box_y_lo) && (y_d < box_y_hi);
      at_ground = (y_d >= GROUND_Y_S);
      off_left  = (x_d < 13'sd0);
      off_right = (x_d > X_MAX_S);
      term      = in_box | at_ground | off_left | off_right;

      // A hit lies inside the box, so it never needs clamping. Any other
      // ending keeps x on screen, and a ground ending also pins y.
      x_clamped = x_d;
      if (!in_box) begin
         if (off_left) begin
            x_clamped = 13'sd0;
         end else if (off_right) begin
            x_clamped = X_MAX_S;
         end
      end
      y_clamped = (!in_box && at_ground) ? GROUND_Y_S : y_d;
   end

   // Flight controller: state, physics registers and registered outputs.
   always_ff @(posedge clk60MHz or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         throw_q <= 1'b0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         vx_q    <= '0;
         vy_q    <= '0;
         x_q     <= CAT_X_S;
         y_q     <= CAT_Y_S;
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
         hit_q   <= 1'b0;
`ifdef PARTICLE_WIND_EN
         wind_q  <= '0;
         phase_q <= '0;
`endif
      end else begin
         throw_q <= throw_flag;
         end_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               x_q <= launch_x;
               y_q <= launch_y;
               if (rise) begin
                  state_q <= FLIGHT;
                  busy_q  <= 1'b1;
                  hit_q   <= 1'b0;
                  cnt_q   <= '0;
                  dir_q   <= turn;
                  vx_q    <= 13'sd1 + $signed({10'd0, power[4:2]});
                  vy_q    <= -(13'sd4 + $signed({9'd0, power[4:1]}));
`ifdef PARTICLE_WIND_EN
                  wind_q  <= wind;
                  phase_q <= '0;
`endif
               end
            end
            FLIGHT: begin
               if (tick) begin
                  cnt_q <= '0;
                  x_q   <= x_clamped;
                  y_q   <= y_clamped;
                  vy_q  <= vy_d;
`ifdef PARTICLE_WIND_EN
                  phase_q <= phase_q + 2'd1;
`endif
                  if (term) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     end_q   <= 1'b1;
                     hit_q   <= in_box;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               x_q     <= launch_x;
               y_q     <= launch_y;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign xpos_particle = x_q[11:0];
   assign ypos_particle = y_q[11:0];
   assign busy          = busy_q;
   assign end_throw     = end_q;
   assign hit           = hit_q;

`ifdef PARTICLE_WIND_EN
   assign unused_bits = ^{x_q[12], y_q[12], power[0]};
`else
   assign unused_bits = ^{x_q[12], y_q[12], power[0], wind};
`endif

endmodule

// File: tb/tb_particle_flight.sv
// Bench for particle_flight: three instances with different opponent-box
// placements share one stimulus stream and are compared every cycle with
// a trajectory model built from the game's flight rules.
module tb_particle_flight;

   localparam int TD = 4;
`ifdef PARTICLE_WIND_EN
   localparam bit WIND_EN = 1'b1;
`else
   localparam bit WIND_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        throw_flag;
   logic        turn;
   logic [4:0]  power;
   logic [2:0]  wind;
   logic [11:0] xo[3];
   logic [11:0] yo[3];
   logic        bo[3];
   logic        eo[3];
   logic        ho[3];

   always #5 clk = ~clk;

   particle_flight #(.TICK_DIV(TD)) u_def (
      .clk60MHz(clk), .rst(rst), .throw_flag(throw_flag), .turn(turn),
      .power(power), .wind(wind), .xpos_particle(xo[0]), .ypos_particle(yo[0]),
      .busy(bo[0]), .end_throw(eo[0]), .hit(ho[0]));

   particle_flight #(.TICK_DIV(TD), .DOG_X(20)) u_edge (
      .clk60MHz(clk), .rst(rst), .throw_flag(throw_flag), .turn(turn),
      .power(power), .wind(wind), .xpos_particle(xo[1]), .ypos_particle(yo[1]),
      .busy(bo[1]), .end_throw(eo[1]), .hit(ho[1]));

   particle_flight #(.TICK_DIV(TD), .DOG_X(125), .DOG_Y(420)) u_tgt (
      .clk60MHz(clk), .rst(rst), .throw_flag(throw_flag), .turn(turn),
      .power(power), .wind(wind), .xpos_particle(xo[2]), .ypos_particle(yo[2]),
      .busy(bo[2]), .end_throw(eo[2]), .hit(ho[2]));

   int          n_assert;
   int          n_fail;
   int          mx[3][64];
   int          my[3][64];
   int          mn[3];
   bit          mhit[3];
   logic [11:0] fin_x[3];
   logic [11:0] fin_y[3];
   logic        fin_hit[3];
   int          end_cnt[3];
   logic [11:0] cap_x[64];
   logic [11:0] cap_y[64];

   function automatic int dog_x(input int i);
      return (i == 1) ? 20 : (i == 2) ? 125 : 660;
   endfunction

   function automatic int dog_y(input int i);
      return (i == 2) ? 420 : 500;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Whole trajectory of one throw for instance i, tick by tick.
   task automatic model(input int i, input bit t, input int p, input int w);
      int x, y, vx, vy, dir, bx, by, n;
      bit done;
      x   = t ? dog_x(i) : 100;
      y   = t ? dog_y(i) : 500;
      bx  = t ? 100 : dog_x(i);
      by  = t ? 500 : dog_y(i);
      dir = t ? -1 : 1;
      vx  = 1 + p / 4;
      vy  = -(4 + p / 2);
      mx[i][0] = x;
      my[i][0] = y;
      mhit[i]  = 1'b0;
      n    = 0;
      done = 1'b0;
      while (!done && n < 63) begin
         n++;
         x = x + dir * vx;
         if (WIND_EN && (n % 4 == 0)) x = x + w - 4;
         y  = y + vy;
         vy = vy + 1;
         if (x >= bx && x < bx + 64 && y >= by && y < by + 64) begin
            mhit[i] = 1'b1;
            done    = 1'b1;
         end else if (y >= 560) begin
            y    = 560;
            x    = (x < 0) ? 0 : (x > 799) ? 799 : x;
            done = 1'b1;
         end else if (x < 0) begin
            x    = 0;
            done = 1'b1;
         end else if (x > 799) begin
            x    = 799;
            done = 1'b1;
         end
         mx[i][n] = x;
         my[i][n] = y;
      end
      mn[i] = n;
   endtask

   task automatic chk_reset_vals(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_x%0d", tag, i), xo[i], 100);
         chk($sformatf("%s_y%0d", tag, i), yo[i], 500);
         chk($sformatf("%s_busy%0d", tag, i), bo[i], 0);
         chk($sformatf("%s_end%0d", tag, i), eo[i], 0);
         chk($sformatf("%s_hit%0d", tag, i), ho[i], 0);
      end
   endtask

   // Launch one throw and compare all instances every cycle until all are idle.
   // abort_k >= 0 asserts rst at that cycle instead of finishing the flight.
   task automatic run_flight(input bit t, input int p, input int w,
                             input bit pulses, input int abort_k);
      int e[3];
      int emin, emax;
      logic et;
      logic [31:0] ex, ey, eb, ee, eh;
      emin = 1 << 30;
      emax = 0;
      for (int i = 0; i < 3; i++) begin
         model(i, t, p, w);
         e[i] = mn[i] * TD;
         end_cnt[i] = 0;
         if (e[i] < emin) emin = e[i];
         if (e[i] > emax) emax = e[i];
      end
      throw_flag = 1'b0;
      @(negedge clk);
      turn       = t;
      power      = p[4:0];
      wind       = w[2:0];
      throw_flag = 1'b1;
      et         = t;
      @(posedge clk);
      for (int k = 0; k <= emax + 2; k++) begin
         @(negedge clk);
         if (k == abort_k) begin
            rst = 1'b1;
            #1;
            chk_reset_vals("abort");
            repeat (3) begin
               @(negedge clk);
               chk_reset_vals("abort_hold");
            end
            rst        = 1'b0;
            throw_flag = 1'b0;
            turn       = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
               chk($sformatf("post_rst_x%0d", i), xo[i], dog_x(i));
               chk($sformatf("post_rst_y%0d", i), yo[i], dog_y(i));
               chk($sformatf("post_rst_busy%0d", i), bo[i], 0);
            end
            return;
         end
         for (int i = 0; i < 3; i++) begin
            if (k < e[i]) begin
               ex = mx[i][k / TD]; ey = my[i][k / TD];
               eb = 1; ee = 0; eh = 0;
            end else if (k == e[i]) begin
               ex = mx[i][mn[i]]; ey = my[i][mn[i]];
               eb = 0; ee = 1; eh = mhit[i];
            end else begin
               ex = et ? dog_x(i) : 100; ey = et ? dog_y(i) : 500;
               eb = 0; ee = 0; eh = mhit[i];
            end
            chk($sformatf("x%0d_k%0d", i, k), xo[i], ex);
            chk($sformatf("y%0d_k%0d", i, k), yo[i], ey);
            chk($sformatf("busy%0d_k%0d", i, k), bo[i], eb);
            chk($sformatf("end%0d_k%0d", i, k), eo[i], ee);
            chk($sformatf("hit%0d_k%0d", i, k), ho[i], eh);
            if (eo[i] === 1'b1) end_cnt[i]++;
            if (k == e[i]) begin
               fin_x[i]   = xo[i];
               fin_y[i]   = yo[i];
               fin_hit[i] = ho[i];
            end
         end
         if (k % TD == 0 && k <= e[0]) begin
            cap_x[k / TD] = xo[0];
            cap_y[k / TD] = yo[0];
         end
         // Later input changes and extra throw edges must not disturb a flight.
         turn       = 1'($urandom);
         power      = 5'($urandom);
         wind       = 3'($urandom);
         throw_flag = (pulses && k < emin) ? (k % 3 == 1) : 1'b0;
         @(posedge clk);
         et = turn;
      end
      throw_flag = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1);
   end

   initial begin
      logic te;
      n_assert   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      throw_flag = 1'b0;
      turn       = 1'b0;
      power      = '0;
      wind       = '0;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;

      // Idle outputs follow the launch point of the current turn.
      for (int j = 0; j < 6; j++) begin
         turn = 1'($urandom);
         @(posedge clk);
         te = turn;
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("idle_x%0d", i), xo[i], te ? dog_x(i) : 100);
            chk($sformatf("idle_y%0d", i), yo[i], te ? dog_y(i) : 500);
            chk($sformatf("idle_busy%0d", i), bo[i], 0);
         end
      end

      // Weakest throw from the cat.
      run_flight(1'b0, 0, 0, 1'b0, -1);
      chk("A_t1_x", cap_x[1], 101);
      chk("A_t1_y", cap_y[1], 496);
      chk("A_t2_x", cap_x[2], 102);
      chk("A_t2_y", cap_y[2], 493);
      chk("A_t3_x", cap_x[3], 103);
      chk("A_t3_y", cap_y[3], 491);
`ifdef PARTICLE_WIND_EN
      chk("F_t4_x", cap_x[4], 100);
`endif

      // Strongest cat throw lands on the ground.
      run_flight(1'b0, 31, 4, 1'b1, -1);
      chk("B_final_y", fin_y[0], 560);
      chk("B_end_len", end_cnt[0], 1);

      // Dog launched near the left edge runs off screen.
      run_flight(1'b1, 31, 4, 1'b1, -1);
      chk("C_final_x", fin_x[1], 0);
      chk("C_hit", fin_hit[1], 0);
      chk("C_end_len", end_cnt[1], 1);

      // Target box placed on the trajectory at tick 5.
      run_flight(1'b0, 16, 4, 1'b1, -1);
      chk("D_hit", fin_hit[2], 1);
      chk("D_end_len", end_cnt[2], 1);

      for (int r = 0; r < 8; r++) begin
         run_flight(1'($urandom), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 7)), 1'b1, -1);
      end

      // Reset during a flight, with extra throw edges beforehand.
      run_flight(1'b0, 20, 3, 1'b1, 3 * TD);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
